// File: rtl/randseq_pkg.sv
// rtl/randseq_pkg.sv - shared types, constants and LFSR step for the token sequencer
package randseq_pkg;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

    typedef enum logic [2:0] {
        TOK_NONE  = 3'd0,
        TOK_ADD   = 3'd1,
        TOK_SUB   = 3'd2,
        TOK_ONE   = 3'd3,
        TOK_TWO   = 3'd4,
        TOK_THREE = 3'd5,
        TOK_DONE  = 3'd6
    } tok_code_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OP   = 3'd1,
        ST_OPND = 3'd2,
        ST_SKIP = 3'd3,
        ST_DN   = 3'd4
    } state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_POLY : '0);
    endfunction

endpackage

// File: rtl/randseq_lfsr.sv
// rtl/randseq_lfsr.sv - 16-bit Galois LFSR with load/step/hold
module randseq_lfsr
    import randseq_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_VAL = 16'h0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SEED_VAL;
        end else if (load) begin
            q <= SEED_VAL;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/randseq_token_sequencer.sv
// rtl/randseq_token_sequencer.sv - emits op/operand/done token sequences chosen by an LFSR
module randseq_token_sequencer
    import randseq_pkg::*;
#(
    parameter int N_SEQ = 4,
    parameter logic [LFSR_W-1:0] SEED = 16'h0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        tok_ready_i,
    output logic        tok_valid_o,
    output logic [2:0]  tok_code_o,
    output logic        busy_o,
    output logic        seq_done_o,
    output logic [15:0] seq_cnt_o
);

    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? 16'h0001 : SEED;
    localparam logic [15:0] N_SEQ_W = 16'(N_SEQ);

    state_e            state, state_n;
    tok_code_e         tok_code, tok_code_n;
    logic              tok_valid, tok_valid_n;
    logic [LFSR_W-1:0] lfsr, lfsr_n;
    logic              lfsr_load, lfsr_step;
    logic [15:0]       remaining, remaining_n;
    logic [15:0]       seq_cnt;
    logic              hs, cnt_inc;

    randseq_lfsr #(.SEED_VAL(SEED_EFF)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .step (lfsr_step),
        .q    (lfsr)
    );

    assign hs = tok_valid & tok_ready_i;

    always_comb begin
        state_n     = state;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;
        remaining_n = remaining;
        cnt_inc     = 1'b0;
        if (abort_i) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        lfsr_load   = 1'b1;
                        remaining_n = N_SEQ_W;
                        state_n     = ST_OP;
                    end
                end
                ST_OP: begin
                    if (hs) begin
                        lfsr_step = 1'b1;
                        state_n   = ST_OPND;
                    end
                end
                ST_OPND: begin
                    // low bits 3 is the rejected operand choice: draw again after one bubble
                    if (lfsr[1:0] == 2'b11) begin
                        lfsr_step = 1'b1;
                        state_n   = ST_SKIP;
                    end else if (hs) begin
                        lfsr_step = 1'b1;
                        state_n   = ST_DN;
                    end
                end
                ST_SKIP: state_n = ST_OPND;
                ST_DN: begin
                    if (hs) begin
                        cnt_inc     = 1'b1;
                        remaining_n = remaining - 16'd1;
                        state_n     = (remaining == 16'd1) ? ST_IDLE : ST_OP;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Look ahead at the next state and LFSR value so the token outputs can be registered
    always_comb begin
        lfsr_n      = lfsr_load ? SEED_EFF : (lfsr_step ? lfsr_next(lfsr) : lfsr);
        tok_valid_n = 1'b0;
        tok_code_n  = TOK_NONE;
        case (state_n)
            ST_OP: begin
                tok_valid_n = 1'b1;
                tok_code_n  = lfsr_n[0] ? TOK_SUB : TOK_ADD;
            end
            ST_OPND: begin
                case (lfsr_n[1:0])
                    2'd0:    begin tok_valid_n = 1'b1; tok_code_n = TOK_ONE;   end
                    2'd1:    begin tok_valid_n = 1'b1; tok_code_n = TOK_TWO;   end
                    2'd2:    begin tok_valid_n = 1'b1; tok_code_n = TOK_THREE; end
                    default: begin tok_valid_n = 1'b0; tok_code_n = TOK_NONE;  end
                endcase
            end
            ST_DN: begin
                tok_valid_n = 1'b1;
                tok_code_n  = TOK_DONE;
            end
            default: begin
                tok_valid_n = 1'b0;
                tok_code_n  = TOK_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= 16'd0;
            seq_cnt   <= 16'd0;
            tok_valid <= 1'b0;
            tok_code  <= TOK_NONE;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            tok_valid <= tok_valid_n;
            tok_code  <= tok_code_n;
            if (cnt_inc) begin
                seq_cnt <= seq_cnt + 16'd1;
            end
        end
    end

    assign tok_valid_o = tok_valid;
    assign tok_code_o  = tok_code;
    assign busy_o      = (state != ST_IDLE);
    assign seq_done_o  = cnt_inc;
    assign seq_cnt_o   = seq_cnt;

endmodule
